// File: rtl/rram_adc_pkg.sv
// Shared definitions for the RRAM ADC segment accumulator.
//   - Default widths for the channel count, thermometer code, accumulator and
//     output word.
//   - FSM state encoding.
//   - Helpers for thermometer decoding and for output packing geometry.
// Thermometer codes wider than THERM_MAX bits are not supported.
package rram_adc_pkg;

  localparam int NUM_ADC_DEF         = 32;
  localparam int ADC_WIDTH_THERM_DEF = 15;
  localparam int ADC_WIDTH_DEF       = 4;
  localparam int PHD_ACC_WIDTH_DEF   = 16;
  localparam int DATAOUT_WIDTH_DEF   = 64;
  localparam int MAX_SEG_SAMPLES_DEF = 64;

  // Codes are zero-extended to this width before decoding, so one function
  // serves every ADC_WIDTH_THERM.
  localparam int THERM_MAX = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2
  } state_e;

  // Channels per output word.
  function automatic int calc_cpw(input int dataout_width, input int acc_width);
    return dataout_width / acc_width;
  endfunction

  // Output words needed to drain num_adc channels.
  function automatic int calc_nwords(input int num_adc, input int cpw);
    return (num_adc + cpw - 1) / cpw;
  endfunction

  localparam int CPW    = calc_cpw(DATAOUT_WIDTH_DEF, PHD_ACC_WIDTH_DEF);
  localparam int NWORDS = calc_nwords(NUM_ADC_DEF, CPW);

  // Counting ones rather than finding the top set bit makes a single bubble
  // in the code cost at most one LSB instead of a large error.
  function automatic int unsigned popcount_therm(input logic [THERM_MAX-1:0] code);
    int unsigned n;
    n = 0;
    for (int i = 0; i < THERM_MAX; i++) begin
      if (code[i]) n++;
    end
    return n;
  endfunction

  // Legal thermometer code: ones contiguous from the LSB. Adding one to such a
  // code yields a single bit above the run, so the AND with the original is 0.
  function automatic logic is_therm(input logic [THERM_MAX-1:0] code);
    logic [THERM_MAX-1:0] inc;
    inc = code + {{(THERM_MAX-1){1'b0}}, 1'b1};
    return ((code & inc) == '0);
  endfunction

endpackage

// File: rtl/rram_therm_decode.sv
// One ADC channel's thermometer-to-binary decoder.
// Ports:
//   code_i     thermometer code from the ADC
//   count_o    number of ones in code_i
//   illegal_o  (only with RRAM_ADC_THERM_CHECK_EN) code_i is not a legal
//              thermometer code
module rram_therm_decode
  import rram_adc_pkg::*;
#(
  parameter int ADC_WIDTH_THERM = ADC_WIDTH_THERM_DEF,
  parameter int ADC_WIDTH       = $clog2(ADC_WIDTH_THERM + 1)
) (
  input  logic [ADC_WIDTH_THERM-1:0] code_i,
  output logic [ADC_WIDTH-1:0]       count_o
`ifdef RRAM_ADC_THERM_CHECK_EN
  ,
  output logic                       illegal_o
`endif
);

  logic [THERM_MAX-1:0] code_ext;

  assign code_ext = THERM_MAX'(code_i);
  assign count_o  = ADC_WIDTH'(popcount_therm(code_ext));

`ifdef RRAM_ADC_THERM_CHECK_EN
  assign illegal_o = !is_therm(code_ext);
`endif

endmodule

// File: rtl/rram_adc_segment_accumulator.sv
// ADC readout back-end for the RRAM crossbar controller.
// Captures NUM_ADC thermometer-coded samples per strobe, decodes them by
// popcount, accumulates per channel (saturating) over a programmed number of
// samples, then drains the accumulators to the output FIFO as packed words.
// Optional macro RRAM_ADC_THERM_CHECK_EN adds sticky per-channel illegal-code
// flags on therm_err.
// Ports:
//   CLK, rst_n     clock; asynchronous active-low reset
//   start          one-cycle command strobe, accepted only in IDLE
//   acc_clear      with start: zero accumulators (and therm_err) first
//   seg_len        with start: samples to accumulate; 0 = dump only
//   sample_valid   ADC_outp carries a sample this cycle
//   ADC_outp       channel i at [i*ADC_WIDTH_THERM +: ADC_WIDTH_THERM]
//   push_n_oFIFO   active-low push to the output FIFO
//   full_oFIFO     output FIFO full, stalls the drain
//   din_oFIFO      current packed word, lowest channel in the LSBs
//   busy           not IDLE
//   done           one-cycle pulse after the last word is pushed
//   therm_err      (macro only) sticky illegal-code flag per channel
module rram_adc_segment_accumulator
  import rram_adc_pkg::*;
#(
  parameter int NUM_ADC         = NUM_ADC_DEF,
  parameter int ADC_WIDTH_THERM = ADC_WIDTH_THERM_DEF,
  parameter int ADC_WIDTH       = $clog2(ADC_WIDTH_THERM + 1),
  parameter int PHD_ACC_WIDTH   = PHD_ACC_WIDTH_DEF,
  parameter int DATAOUT_WIDTH   = DATAOUT_WIDTH_DEF,
  parameter int MAX_SEG_SAMPLES = MAX_SEG_SAMPLES_DEF
) (
  input  logic                                 CLK,
  input  logic                                 rst_n,
  input  logic                                 start,
  input  logic                                 acc_clear,
  input  logic [$clog2(MAX_SEG_SAMPLES+1)-1:0] seg_len,
  input  logic                                 sample_valid,
  input  logic [NUM_ADC*ADC_WIDTH_THERM-1:0]   ADC_outp,
  output logic                                 push_n_oFIFO,
  input  logic                                 full_oFIFO,
  output logic [DATAOUT_WIDTH-1:0]             din_oFIFO,
  output logic                                 busy,
  output logic                                 done
`ifdef RRAM_ADC_THERM_CHECK_EN
  ,
  output logic [NUM_ADC-1:0]                   therm_err
`endif
);

  localparam int SEG_W    = $clog2(MAX_SEG_SAMPLES + 1);
  localparam int CPW_P    = calc_cpw(DATAOUT_WIDTH, PHD_ACC_WIDTH);
  localparam int NWORDS_P = calc_nwords(NUM_ADC, CPW_P);
  localparam int WIDX_W   = (NWORDS_P > 1) ? $clog2(NWORDS_P) : 1;

  state_e             state_q, state_d;
  logic [SEG_W-1:0]   seg_len_q, seg_len_d;
  logic [SEG_W-1:0]   cnt_q, cnt_d;
  logic [WIDX_W-1:0]  widx_q, widx_d;
  logic               done_q, done_d;
  logic               acc_clr;
  logic               acc_en;
  logic               push;

  logic [PHD_ACC_WIDTH-1:0] acc_q   [NUM_ADC];
  logic [PHD_ACC_WIDTH-1:0] acc_sat [NUM_ADC];
  logic [ADC_WIDTH-1:0]     count   [NUM_ADC];
  logic [DATAOUT_WIDTH-1:0] words   [NWORDS_P];

`ifdef RRAM_ADC_THERM_CHECK_EN
  logic [NUM_ADC-1:0] illegal;
  logic [NUM_ADC-1:0] therm_err_q;
`endif

  // Per-channel decode and saturating add.
  for (genvar g = 0; g < NUM_ADC; g++) begin : g_chan
    logic [PHD_ACC_WIDTH:0] sum;

    rram_therm_decode #(
      .ADC_WIDTH_THERM (ADC_WIDTH_THERM),
      .ADC_WIDTH       (ADC_WIDTH)
    ) u_dec (
      .code_i    (ADC_outp[g*ADC_WIDTH_THERM +: ADC_WIDTH_THERM]),
      .count_o   (count[g])
`ifdef RRAM_ADC_THERM_CHECK_EN
      ,
      .illegal_o (illegal[g])
`endif
    );

    // One extra bit catches the carry out; on carry the field clamps to all ones.
    assign sum        = {1'b0, acc_q[g]} + (PHD_ACC_WIDTH+1)'(count[g]);
    assign acc_sat[g] = sum[PHD_ACC_WIDTH] ? '1 : sum[PHD_ACC_WIDTH-1:0];
  end

  // Output words; fields past the last channel read as zero.
  for (genvar k = 0; k < NWORDS_P; k++) begin : g_word
    for (genvar j = 0; j < CPW_P; j++) begin : g_field
      if (k*CPW_P + j < NUM_ADC) begin : g_used
        assign words[k][j*PHD_ACC_WIDTH +: PHD_ACC_WIDTH] = acc_q[k*CPW_P + j];
      end else begin : g_pad
        assign words[k][j*PHD_ACC_WIDTH +: PHD_ACC_WIDTH] = '0;
      end
    end
  end

  assign push         = (state_q == DRAIN) && !full_oFIFO;
  assign push_n_oFIFO = !push;
  assign din_oFIFO    = words[widx_q];
  assign busy         = (state_q != IDLE);
  assign done         = done_q;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d   = state_q;
    seg_len_d = seg_len_q;
    cnt_d     = cnt_q;
    widx_d    = widx_q;
    done_d    = 1'b0;
    acc_clr   = 1'b0;
    acc_en    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          acc_clr   = acc_clear;
          seg_len_d = seg_len;
          cnt_d     = '0;
          widx_d    = '0;
          state_d   = (seg_len == '0) ? DRAIN : ACCUM;
        end
      end

      ACCUM: begin
        if (sample_valid) begin
          acc_en = 1'b1;
          cnt_d  = cnt_q + SEG_W'(1);
          if (cnt_d == seg_len_q) begin
            cnt_d   = '0;
            state_d = DRAIN;
          end
        end
      end

      DRAIN: begin
        if (push) begin
          if (widx_q == WIDX_W'(NWORDS_P - 1)) begin
            widx_d  = '0;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            widx_d = widx_q + WIDX_W'(1);
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of block ordering.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      seg_len_q <= '0;
      cnt_q     <= '0;
      widx_q    <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      seg_len_q <= seg_len_d;
      cnt_q     <= cnt_d;
      widx_q    <= widx_d;
      done_q    <= done_d;
    end
  end

  // NOTE: the accumulator array is built from flops, not a RAM macro, and must
  // read zero straight after reset, so it takes the asynchronous reset too.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_ADC; i++) acc_q[i] <= '0;
    end else if (acc_clr) begin
      for (int i = 0; i < NUM_ADC; i++) acc_q[i] <= '0;
    end else if (acc_en) begin
      for (int i = 0; i < NUM_ADC; i++) acc_q[i] <= acc_sat[i];
    end
  end

`ifdef RRAM_ADC_THERM_CHECK_EN
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      therm_err_q <= '0;
    end else if (acc_clr) begin
      therm_err_q <= '0;
    end else if (acc_en) begin
      therm_err_q <= therm_err_q | illegal;
    end
  end

  assign therm_err = therm_err_q;
`endif

endmodule

// File: tb/tb_rram_adc_segment_accumulator.sv
// Directed bench for rram_adc_segment_accumulator. A second instance with an
// 8-bit accumulator covers saturation with four-word drains.
module tb_rram_adc_segment_accumulator;

  localparam int NUM_ADC = 32;
  localparam int THW     = 15;
  localparam int SEGW    = 7;
  localparam int NW      = 8;
  localparam int CPW     = 4;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic                     rst_n;
  logic                     start, start_8, acc_clear, sample_valid, full_oFIFO;
  logic [SEGW-1:0]          seg_len;
  logic [NUM_ADC*THW-1:0]   ADC_outp;
  logic                     push_n_oFIFO, busy, done;
  logic [63:0]              din_oFIFO;
  logic                     push_n_8, busy_8, done_8;
  logic [63:0]              din_8;
`ifdef RRAM_ADC_THERM_CHECK_EN
  logic [NUM_ADC-1:0]       therm_err, therm_err_8;
`endif

  rram_adc_segment_accumulator dut (
    .CLK          (CLK),
    .rst_n        (rst_n),
    .start        (start),
    .acc_clear    (acc_clear),
    .seg_len      (seg_len),
    .sample_valid (sample_valid),
    .ADC_outp     (ADC_outp),
    .push_n_oFIFO (push_n_oFIFO),
    .full_oFIFO   (full_oFIFO),
    .din_oFIFO    (din_oFIFO),
    .busy         (busy),
    .done         (done)
`ifdef RRAM_ADC_THERM_CHECK_EN
    ,
    .therm_err    (therm_err)
`endif
  );

  rram_adc_segment_accumulator #(.PHD_ACC_WIDTH(8)) dut8 (
    .CLK          (CLK),
    .rst_n        (rst_n),
    .start        (start_8),
    .acc_clear    (acc_clear),
    .seg_len      (seg_len),
    .sample_valid (sample_valid),
    .ADC_outp     (ADC_outp),
    .push_n_oFIFO (push_n_8),
    .full_oFIFO   (full_oFIFO),
    .din_oFIFO    (din_8),
    .busy         (busy_8),
    .done         (done_8)
`ifdef RRAM_ADC_THERM_CHECK_EN
    ,
    .therm_err    (therm_err_8)
`endif
  );

  int checks   = 0;
  int failures = 0;

  int unsigned    exp_acc [NUM_ADC];
  logic [THW-1:0] codes   [NUM_ADC];
  bit             chk8;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [63:0] exp_word(input int k);
    logic [63:0] w;
    w = '0;
    for (int j = 0; j < CPW; j++) begin
      if (k*CPW + j < NUM_ADC) w[j*16 +: 16] = 16'(exp_acc[k*CPW + j]);
    end
    return w;
  endfunction

  task automatic set_codes(input logic [THW-1:0] c);
    for (int i = 0; i < NUM_ADC; i++) codes[i] = c;
  endtask

  task automatic clear_model();
    for (int i = 0; i < NUM_ADC; i++) exp_acc[i] = 0;
  endtask

  // Drives start at a falling edge; returns one cycle later with start low.
  task automatic issue_cmd(input logic clr, input int len, input bit also8);
    @(negedge CLK);
    start     = 1'b1;
    start_8   = also8;
    acc_clear = clr;
    seg_len   = SEGW'(len);
    if (clr) clear_model();
    @(negedge CLK);
    start     = 1'b0;
    start_8   = 1'b0;
    acc_clear = 1'b0;
    check("busy_after_start", 64'(busy), 64'd1);
  endtask

  task automatic send_samples(input int n);
    for (int s = 0; s < n; s++) begin
      sample_valid = 1'b1;
      for (int i = 0; i < NUM_ADC; i++) begin
        ADC_outp[i*THW +: THW] = codes[i];
        exp_acc[i] = exp_acc[i] + $countones(codes[i]);
        if (exp_acc[i] > 65535) exp_acc[i] = 65535;
      end
      @(negedge CLK);
    end
    sample_valid = 1'b0;
  endtask

  // Follows one drain. With stall_len>0, holds full high for stall_len cycles
  // once stall_at words have gone, and fires a start in the middle of it.
  task automatic drain(input int stall_at, input int stall_len, input string tag);
    int pushes, pushes8, dones, dones8, stall_left, first;
    pushes = 0; pushes8 = 0; dones = 0; dones8 = 0;
    stall_left = stall_len; first = -1;
    for (int c = 0; c < 60 && dones == 0; c++) begin
      if (pushes == stall_at && stall_left > 0) begin
        full_oFIFO = 1'b1;
        start      = (stall_left == 3);
        acc_clear  = (stall_left == 3);
        seg_len    = SEGW'(5);
      end else begin
        full_oFIFO = 1'b0;
        start      = 1'b0;
        acc_clear  = 1'b0;
      end
      #1;
      if (full_oFIFO) begin
        check($sformatf("%s_stall_push_n", tag), 64'(push_n_oFIFO), 64'd1);
        check($sformatf("%s_stall_hold", tag), din_oFIFO, exp_word(pushes));
        stall_left--;
      end else if (!push_n_oFIFO) begin
        if (first < 0) first = c;
        check($sformatf("%s_word%0d", tag, pushes), din_oFIFO, exp_word(pushes));
        pushes++;
      end
      if (chk8 && !push_n_8) begin
        check($sformatf("%s_w8_word%0d", tag, pushes8), din_8, 64'hFFFF_FFFF_FFFF_FFFF);
        pushes8++;
      end
      if (chk8 && done_8) dones8++;
      if (done) dones++;
      @(negedge CLK);
    end
    full_oFIFO = 1'b0;
    start      = 1'b0;
    acc_clear  = 1'b0;
    check($sformatf("%s_push_count", tag), 64'(pushes), 64'(NW));
    check($sformatf("%s_done_seen", tag), 64'(dones), 64'd1);
    check($sformatf("%s_first_push_latency", tag), 64'(first), 64'd0);
    #1;
    check($sformatf("%s_done_single", tag), 64'(done), 64'd0);
    check($sformatf("%s_idle", tag), 64'(busy), 64'd0);
    if (chk8) begin
      check($sformatf("%s_w8_push_count", tag), 64'(pushes8), 64'd4);
      check($sformatf("%s_w8_done", tag), 64'(dones8), 64'd1);
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; start_8 = 1'b0; acc_clear = 1'b0;
    seg_len = '0; sample_valid = 1'b0; full_oFIFO = 1'b0; ADC_outp = '0;
    chk8 = 1'b0;
    clear_model();
    set_codes('0);

    // Reset values.
    repeat (2) @(negedge CLK);
    check("rst_push_n", 64'(push_n_oFIFO), 64'd1);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_din", din_oFIFO, 64'd0);
    check("rst_done", 64'(done), 64'd0);
`ifdef RRAM_ADC_THERM_CHECK_EN
    check("rst_therm_err", 64'(therm_err), 64'd0);
`endif
    rst_n = 1'b1;

    // Read-only dump after reset: eight zero words.
    issue_cmd(1'b1, 0, 1'b0);
    drain(-1, 0, "dump0");

    // Two samples of 8 ones per channel: every field 16.
    set_codes(15'h00FF);
    issue_cmd(1'b1, 2, 1'b0);
    send_samples(2);
    drain(-1, 0, "basic");
    check("basic_field", 64'(exp_acc[31]), 64'h10);
`ifdef RRAM_ADC_THERM_CHECK_EN
    check("basic_therm_err", 64'(therm_err), 64'd0);
`endif

    // Accumulate without clear: 16 + 1 = 17.
    set_codes(15'h0001);
    issue_cmd(1'b0, 1, 1'b0);
    send_samples(1);
    drain(-1, 0, "noclear");
    check("noclear_field", 64'(exp_acc[0]), 64'd17);

    // Bubble code, popcount 7.
    set_codes(15'b010101010101001);
    issue_cmd(1'b1, 1, 1'b0);
    send_samples(1);
    drain(-1, 0, "bubble");
`ifdef RRAM_ADC_THERM_CHECK_EN
    check("bubble_therm_err", 64'(therm_err), 64'hFFFF_FFFF);
`endif

    // Saturation: 18 x 15 = 270 clamps to 255 in the 8-bit instance.
    set_codes(15'h7FFF);
    chk8 = 1'b1;
    issue_cmd(1'b1, 18, 1'b1);
    send_samples(18);
    drain(-1, 0, "sat");
    chk8 = 1'b0;
    check("sat_main_field", 64'(exp_acc[5]), 64'd270);

    // Backpressure with distinct fields: channel i holds i%16.
    for (int i = 0; i < NUM_ADC; i++) codes[i] = THW'((32'd1 << (i % 16)) - 1);
    issue_cmd(1'b1, 1, 1'b0);
    send_samples(1);
    drain(3, 5, "bp");
`ifdef RRAM_ADC_THERM_CHECK_EN
    check("bp_therm_err", 64'(therm_err), 64'd0);
`endif

    // Reset in the middle of a drain.
    issue_cmd(1'b0, 0, 1'b0);
    repeat (2) @(negedge CLK);
    #1;
    rst_n = 1'b0;
    clear_model();
    #1;
    check("midrst_push_n", 64'(push_n_oFIFO), 64'd1);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_din", din_oFIFO, 64'd0);
    for (int c = 0; c < 3; c++) begin
      @(negedge CLK);
      check("midrst_no_push", 64'(push_n_oFIFO), 64'd1);
    end
    rst_n = 1'b1;
    issue_cmd(1'b0, 0, 1'b0);
    drain(-1, 0, "postrst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rram_adc_segment_accumulator.md
Name: rram_adc_segment_accumulator

Overview:
Parametrised ADC readout back-end for the RRAM crossbar controller.
- Captures NUM_ADC thermometer-coded ADC outputs per sample strobe.
- Decodes each code to binary by popcount, so single-bubble codes are tolerated.
- Accumulates per channel over a programmable segment length (Hamming segment compute, generalised in channel count and widths).
- Drains the accumulators to the output data FIFO as packed DATAOUT_WIDTH words over a push_n/full handshake.

Parameters:
- NUM_ADC, 32, number of ADC channels.
- ADC_WIDTH_THERM, 15, thermometer bits per channel.
- ADC_WIDTH, $clog2(ADC_WIDTH_THERM+1) = 4, decoded sample width.
- PHD_ACC_WIDTH, 16, per-channel accumulator width (saturating).
- DATAOUT_WIDTH, 64, output FIFO word width. Must be a multiple of PHD_ACC_WIDTH.
- MAX_SEG_SAMPLES, 64, maximum samples per segment.

Ports:
- CLK  in  1  single clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle command strobe; accepted only in IDLE.
- acc_clear  in  1  sampled with start; 1 = zero all accumulators before accumulating.
- seg_len  in  $clog2(MAX_SEG_SAMPLES+1)  samples to accumulate, sampled with start.
- sample_valid  in  1  ADC_outp valid this cycle.
- ADC_outp  in  NUM_ADC*ADC_WIDTH_THERM  channel i occupies bits [i*ADC_WIDTH_THERM +: ADC_WIDTH_THERM].
- push_n_oFIFO  out  1  active-low push to output FIFO.
- full_oFIFO  in  1  output FIFO full.
- din_oFIFO  out  DATAOUT_WIDTH  packed accumulator word.
- busy  out  1  high when not IDLE.
- done  out  1  one-cycle pulse after the last word is pushed.

Behaviour:
- Reset values: push_n_oFIFO=1, din_oFIFO=0, busy=0, done=0. All accumulators, counters and state are cleared. Reset is asynchronous.
- States: IDLE, ACCUM, DRAIN.
- IDLE -> ACCUM on start when seg_len!=0. Latch seg_len. If acc_clear=1, zero all accumulators on the same edge.
- IDLE -> DRAIN on start when seg_len==0: read-only dump. acc_clear is still honoured.
- start outside IDLE is ignored.
- ACCUM:
  - On each edge with sample_valid=1: acc[i] <= sat(acc[i] + popcount(chan_i)); sample counter increments.
  - When the counter reaches seg_len on that edge, next state is DRAIN.
  - sample_valid outside ACCUM is ignored.
- Saturation: the sum is clamped to 2^PHD_ACC_WIDTH-1; it never wraps.
- Packing:
  - CPW = DATAOUT_WIDTH/PHD_ACC_WIDTH channels per word.
  - NWORDS = ceil(NUM_ADC/CPW) words per drain.
  - Word k holds channels k*CPW..k*CPW+CPW-1, lowest channel in the LSBs.
  - Channels beyond NUM_ADC are padded with 0.
- DRAIN handshake:
  - din_oFIFO = word[widx], combinational from the accumulators.
  - push_n_oFIFO = ~(state==DRAIN && !full_oFIFO), combinational.
  - widx advances on each edge where push_n_oFIFO==0.
  - full_oFIFO held high stalls indefinitely with no data loss.
  - After the push of word NWORDS-1: done=1 for one cycle, state -> IDLE, widx=0.
- Accumulators persist across commands unless acc_clear is given. The drain does not clear them.
- Latency: first push occurs one cycle after entering DRAIN with full_oFIFO=0. NWORDS cycles minimum to drain.
- Reset mid-operation: return to IDLE immediately, no further pushes, accumulators zeroed.

Optional Feature:
RRAM_ADC_THERM_CHECK_EN
- Defined:
  - Adds output therm_err [NUM_ADC], reset value 0.
  - Bit i is set (sticky) when a valid accumulated sample for channel i is not a legal thermometer code (ones contiguous from the LSB).
  - Bits are cleared by start with acc_clear=1.
  - The accumulated value is still popcount.
- Undefined: the port and its logic are absent.

Decomposition:
- Package rram_adc_pkg:
  - Default widths.
  - State enum {IDLE, ACCUM, DRAIN}.
  - Functions popcount_therm() and is_therm().
  - Constants CPW and NWORDS computed from the parameters.
- Sub-module rram_therm_decode: one channel's popcount, plus the legality check under the macro. Instantiated NUM_ADC times via generate.

Test Plan:
- Reset: hold rst_n=0 -> push_n_oFIFO=1, busy=0, din_oFIFO=0. Then start, seg_len=0, acc_clear=1, full=0 -> 8 pushes of 64'h0, then done.
- Basic accumulate: start, acc_clear=1, seg_len=2; two samples with every channel 15'h00FF; full=0 -> 8 words, each 64'h0008_0008_0008_0008 ×2 = 64'h0010_0010_0010_0010; done pulses once.
- Bubble code: all channels 15'b010101010101001, seg_len=1, acc_clear=1 -> every field =7 (words 64'h0007_0007_0007_0007). With RRAM_ADC_THERM_CHECK_EN, therm_err=32'hFFFF_FFFF.
- Saturation: PHD_ACC_WIDTH=8 (CPW=8, NWORDS=4), seg_len=18, all channels 15'h7FFF (18×15=270) -> every field 8'hFF, no wrap.
- Backpressure: full_oFIFO=1 for 5 cycles mid-drain -> push_n stays 1, din_oFIFO holds the current word; on release the remaining words are pushed in order with no duplicate or skip. A start issued during DRAIN is ignored.
- Accumulate without clear plus reset mid-op: second command with acc_clear=0, seg_len=1, code 15'h0001 -> fields 17. Then assert rst_n low during DRAIN -> no pushes, busy=0; a following dump shows all zeros.
